// File: rtl/nes_dp_core_if.sv
// nes_dp_core_if: AXI-Stream audio bus (32-bit data, 1-bit channel id).
interface nes_dp_core_if;
  logic [31:0] tdata;
  logic        tid;
  logic        tvalid;
  logic        tready;
  modport master (output tdata, tid, tvalid, input tready);
  modport slave  (input tdata, tid, tvalid, output tready);
endinterface

// File: rtl/nes_dp_core.sv
// nes_dp_core: NES PPU timing/palette to registered RGB video, plus stereo AXI-Stream audio.
// The audio path is built only when NES_DP_AUDIO_EN is defined; otherwise the bus is tied to 0.
module nes_dp_core #(
  parameter int AUDIO_DIV = 232,
  parameter int HS_START  = 280,
  parameter int HS_END    = 305,
  parameter int VS_START  = 244,
  parameter int VS_END    = 247
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  color_i,
  input  logic [8:0]  scanline_i,
  input  logic [8:0]  cycle_i,
  input  logic [15:0] sample_i,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [23:0] video_o,
  nes_dp_core_if.master axis
);
  localparam logic [23:0] PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };
  logic        de_d, hsync_d, vsync_d;
  logic [23:0] video_d;
  assign de_d    = scanline_i < 9'd240 && cycle_i >= 9'd1 && cycle_i <= 9'd256;
  assign hsync_d = int'(cycle_i) >= HS_START && int'(cycle_i) <= HS_END;
  assign vsync_d = int'(scanline_i) >= VS_START && int'(scanline_i) <= VS_END;
  assign video_d = de_d ? PAL[color_i] : 24'h000000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      de_o    <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      video_o <= 24'h000000;
    end else begin
      de_o    <= de_d;
      hsync_o <= hsync_d;
      vsync_o <= vsync_d;
      video_o <= video_d;
    end
`ifdef NES_DP_AUDIO_EN
  localparam int DW = $clog2(AUDIO_DIV);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} st_t;
  st_t          st_q, st_d;
  logic [DW-1:0] div_q;
  logic [15:0]  smp_q;
  logic         tick;
  assign tick = div_q == DW'(AUDIO_DIV - 1);
  // Ticks outside IDLE (including the RIGHT->IDLE edge) fall through and are dropped.
  assign st_d = (st_q == IDLE) ? (tick ? LEFT : IDLE) :
                (st_q == LEFT) ? (axis.tready ? RIGHT : LEFT) :
                                 (axis.tready ? IDLE : RIGHT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q  <= IDLE;
      div_q <= '0;
      smp_q <= 16'h0000;
    end else begin
      st_q  <= st_d;
      div_q <= tick ? '0 : div_q + DW'(1);
      if (st_q == IDLE && tick) smp_q <= sample_i;
    end
  assign axis.tvalid = st_q != IDLE;
  assign axis.tid    = st_q == RIGHT;
  assign axis.tdata  = {smp_q, 16'h0000};
`else
  logic unused_audio;
  assign unused_audio = ^{axis.tready, sample_i};
  assign axis.tvalid  = 1'b0;
  assign axis.tid     = 1'b0;
  assign axis.tdata   = 32'h0;
`endif
endmodule

// File: tb/tb_nes_dp_core.sv
// tb_nes_dp_core: directed checks of video timing/palette and the AXI-Stream audio pair.
module tb_nes_dp_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  color;
  logic [8:0]  scanline, cycle;
  logic [15:0] sample;
  logic        de, hsync, vsync;
  logic [23:0] video;
  int          total = 0, bad = 0;
  int          n, errs;
  nes_dp_core_if ax();
  nes_dp_core dut (
    .clk(clk), .rst_n(rst_n), .color_i(color), .scanline_i(scanline), .cycle_i(cycle),
    .sample_i(sample), .de_o(de), .hsync_o(hsync), .vsync_o(vsync), .video_o(video), .axis(ax)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic vid(input string tag, input logic [8:0] sl, input logic [8:0] cy, input logic [5:0] col,
                     input logic de_e, input logic hs_e, input logic vs_e, input logic [23:0] v_e);
    scanline = sl;
    cycle    = cy;
    color    = col;
    step();
    chk(tag, {37'd0, de, hsync, vsync, video}, {37'd0, de_e, hs_e, vs_e, v_e});
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!ax.tvalid && cnt < 2000);
  endtask
  initial begin
    ax.tready = 1'b1;
    sample    = 16'h8001;
    scanline  = 9'd10;
    cycle     = 9'd1;
    color     = 6'h16;
    repeat (3) @(negedge clk);
    chk("rst_video", {37'd0, de, hsync, vsync, video}, 64'd0);
    chk("rst_axis", {30'd0, ax.tvalid, ax.tid, ax.tdata}, 64'd0);
    rst_n = 1'b1;
    vid("v_f83800",  9'd10,  9'd1,   6'h16, 1'b1, 1'b0, 1'b0, 24'hF83800);
    vid("v_c257",    9'd10,  9'd257, 6'h20, 1'b0, 1'b0, 1'b0, 24'h000000);
    vid("v_hs290",   9'd10,  9'd290, 6'h20, 1'b0, 1'b1, 1'b0, 24'h000000);
    vid("v_vs245",   9'd245, 9'd100, 6'h20, 1'b0, 1'b0, 1'b1, 24'h000000);
    vid("v_c256",    9'd0,   9'd256, 6'h30, 1'b1, 1'b0, 1'b0, 24'hFCFCFC);
    vid("v_sl239",   9'd239, 9'd100, 6'h01, 1'b1, 1'b0, 1'b0, 24'h0000FC);
    vid("v_sl240",   9'd240, 9'd100, 6'h01, 1'b0, 1'b0, 1'b0, 24'h000000);
    vid("v_c0",      9'd10,  9'd0,   6'h00, 1'b0, 1'b0, 1'b0, 24'h000000);
    vid("v_pal00",   9'd10,  9'd128, 6'h00, 1'b1, 1'b0, 1'b0, 24'h7C7C7C);
    vid("v_pal20",   9'd10,  9'd128, 6'h20, 1'b1, 1'b0, 1'b0, 24'hF8F8F8);
    vid("v_pal0d",   9'd10,  9'd128, 6'h0D, 1'b1, 1'b0, 1'b0, 24'h000000);
    vid("v_pal0f",   9'd10,  9'd128, 6'h0F, 1'b1, 1'b0, 1'b0, 24'h000000);
    vid("v_pal1e",   9'd10,  9'd128, 6'h1E, 1'b1, 1'b0, 1'b0, 24'h000000);
    vid("v_pal3f",   9'd10,  9'd128, 6'h3F, 1'b1, 1'b0, 1'b0, 24'h000000);
    vid("v_hs279",   9'd10,  9'd279, 6'h00, 1'b0, 1'b0, 1'b0, 24'h000000);
    vid("v_hs280",   9'd10,  9'd280, 6'h00, 1'b0, 1'b1, 1'b0, 24'h000000);
    vid("v_hs305",   9'd10,  9'd305, 6'h00, 1'b0, 1'b1, 1'b0, 24'h000000);
    vid("v_hs306",   9'd10,  9'd306, 6'h00, 1'b0, 1'b0, 1'b0, 24'h000000);
    vid("v_vs243",   9'd243, 9'd300, 6'h00, 1'b0, 1'b1, 1'b0, 24'h000000);
    vid("v_vs244",   9'd244, 9'd300, 6'h00, 1'b0, 1'b1, 1'b1, 24'h000000);
    vid("v_vs247",   9'd247, 9'd300, 6'h00, 1'b0, 1'b1, 1'b1, 24'h000000);
    vid("v_vs248",   9'd248, 9'd300, 6'h00, 1'b0, 1'b1, 1'b0, 24'h000000);
    vid("v_again",   9'd10,  9'd1,   6'h16, 1'b1, 1'b0, 1'b0, 24'hF83800);
`ifdef NES_DP_AUDIO_EN
    rst_n     = 1'b0;
    ax.tready = 1'b1;
    sample    = 16'h8001;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    chk("first_tick", 64'(n), 64'd232);
    chk("beat_l", {30'd0, ax.tvalid, ax.tid, ax.tdata}, {30'd0, 1'b1, 1'b0, 32'h80010000});
    sample = 16'h1234;
    step();
    chk("beat_r", {30'd0, ax.tvalid, ax.tid, ax.tdata}, {30'd0, 1'b1, 1'b1, 32'h80010000});
    step();
    chk("idle", 64'(ax.tvalid), 64'd0);
    wait_valid(n);
    chk("period", 64'(n), 64'd230);
    chk("beat2_l", {30'd0, ax.tvalid, ax.tid, ax.tdata}, {30'd0, 1'b1, 1'b0, 32'h12340000});
    step();
    step();
    ax.tready = 1'b0;
    sample    = 16'hABCD;
    wait_valid(n);
    chk("period2", 64'(n), 64'd230);
    sample = 16'h5555;
    errs   = 0;
    repeat (600) begin
      step();
      if ({ax.tvalid, ax.tid, ax.tdata} !== {1'b1, 1'b0, 32'hABCD0000}) errs++;
    end
    chk("hold", 64'(errs), 64'd0);
    ax.tready = 1'b1;
    step();
    chk("drain_r", {30'd0, ax.tvalid, ax.tid, ax.tdata}, {30'd0, 1'b1, 1'b1, 32'hABCD0000});
    step();
    errs = 0;
    repeat (10) begin
      if (ax.tvalid) errs++;
      step();
    end
    chk("drain_done", 64'(errs), 64'd0);
    wait_valid(n);
    chk("period3", 64'(n), 64'd84);
    scanline = 9'd10;
    cycle    = 9'd1;
    color    = 6'h16;
    step();
    chk("pend_r", 64'(ax.tid), 64'd1);
    ax.tready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {5'd0, de, hsync, vsync, video, ax.tvalid, ax.tid, ax.tdata}, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    ax.tready = 1'b1;
    wait_valid(n);
    chk("tick_after_rst", 64'(n), 64'd232);
    chk("beat3_l", {30'd0, ax.tvalid, ax.tid, ax.tdata}, {30'd0, 1'b1, 1'b0, 32'h55550000});
`else
    errs = 0;
    repeat (600) begin
      ax.tready = ~ax.tready;
      step();
      if ({ax.tvalid, ax.tid, ax.tdata} !== 34'd0) errs++;
    end
    chk("audio_off", 64'(errs), 64'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
